// File: rtl/servo_pkg.sv
// Shared defaults, helpers and parameter sanity checks for the multi-channel servo PWM block.
package servo_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 16;
    localparam int PRESC_DEF = 5;
    localparam int CMD_W_DEF = 10;
    localparam int PW_W_DEF  = CNT_W_DEF - PRESC_DEF;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Widths must fit the coarse counter field, and command+offset must not overflow it.
    function automatic bit params_ok(input int nch, input int cnt_w, input int presc,
                                     input int cmd_w, input int pw_min, input int pw_max,
                                     input int fs_frames, input int fs_val);
        int pw_w;
        pw_w = cnt_w - presc;
        if (nch < 1 || presc < 0 || cmd_w < 1 || pw_w < 1 || pw_w > 30) return 1'b0;
        if (pw_w < cmd_w + 1) return 1'b0;
        if (pw_min < 0 || pw_min > pw_max || pw_max >= (1 << pw_w)) return 1'b0;
        if (fs_frames < 0 || fs_val < 0 || fs_val >= (1 << pw_w)) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One PWM channel: shadow command, frame-latched width/enable, failsafe tracking, pulse compare.
// Latency: width latched at the frame boundary, SERVO/STALE registered; writes always accepted.
module servo_channel
    import servo_pkg::*;
#(
    parameter int CMD_W           = CMD_W_DEF,
    parameter int PW_W            = PW_W_DEF,
    parameter int PW_MIN          = 0,
    parameter int PW_MAX          = 2000,
    parameter int FAILSAFE_FRAMES = 8,
    parameter int FAILSAFE_VAL    = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             boundary,
    input  logic [PW_W-1:0]  cnt_hi,
    input  logic             wr,
    input  logic [CMD_W-1:0] wr_cmd,
    input  logic [CMD_W-1:0] offset,
    input  logic             en,
    output logic             servo,
    output logic             stale
);

    localparam bit FS_ON = (FAILSAFE_FRAMES > 0);
    localparam int FS_W  = FS_ON ? $clog2(FAILSAFE_FRAMES + 1) : 1;

    logic [CMD_W-1:0] shadow;
    logic [PW_W-1:0]  active;
    logic             en_q;
    logic [FS_W-1:0]  fs_cnt;

    logic [CMD_W:0]   sum;
    logic [PW_W-1:0]  w_norm;
    logic [PW_W-1:0]  w_lat;
    logic             fs_hit;
    logic             fs_sat;

    always_comb begin
        sum    = {1'b0, shadow} + {1'b0, offset};
        w_norm = PW_W'(clamp(int'(sum), PW_MIN, PW_MAX));
        fs_sat = FS_ON && (int'(fs_cnt) >= FAILSAFE_FRAMES);
        // A write landing on the boundary edge refreshes the channel, so it never goes stale there.
        fs_hit = FS_ON && !wr && (int'(fs_cnt) + 1 >= FAILSAFE_FRAMES);
        w_lat  = (stale || fs_hit) ? PW_W'(FAILSAFE_VAL) : w_norm;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow <= '0;
            active <= '0;
            en_q   <= 1'b0;
            fs_cnt <= '0;
            stale  <= 1'b0;
            servo  <= 1'b0;
        end else begin
            if (boundary) begin
                active <= w_lat;
                en_q   <= en;
                servo  <= en && (w_lat != '0);
            end else if (!en_q || cnt_hi == active) begin
                servo <= 1'b0;
            end

            if (wr) begin
                shadow <= wr_cmd;
                fs_cnt <= '0;
                stale  <= 1'b0;
            end else if (boundary && FS_ON) begin
                if (!fs_sat) fs_cnt <= fs_cnt + FS_W'(1);
                if (fs_hit)  stale  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/servo_multi.sv
// Multi-channel servo/ESC PWM sharing one free-running frame counter; per-channel failsafe.
// Latency: a write applies at the first frame boundary after it; outputs registered; no backpressure.
module servo_multi
    import servo_pkg::*;
#(
    parameter int NCH             = NCH_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int PRESC           = PRESC_DEF,
    parameter int CMD_W           = CMD_W_DEF,
    parameter int PW_MIN          = 0,
    parameter int PW_MAX          = 2000,
    parameter int FAILSAFE_FRAMES = 8,
    parameter int FAILSAFE_VAL    = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WR,
    input  logic [idx_w(NCH)-1:0]  WR_CH,
    input  logic [CMD_W-1:0]       WR_CMD,
    input  logic [NCH*CMD_W-1:0]   OFFSET,
    input  logic [NCH-1:0]         EN,
    output logic [NCH-1:0]         SERVO,
    output logic                   FRAME,
    output logic [NCH-1:0]         STALE
);

    localparam int PW_W = CNT_W - PRESC;

    if (!params_ok(NCH, CNT_W, PRESC, CMD_W, PW_MIN, PW_MAX, FAILSAFE_FRAMES, FAILSAFE_VAL))
    begin : g_param_err
        $error("servo_multi: illegal parameter combination");
    end

    logic [CNT_W-1:0] cnt;
    logic             boundary;
    logic [PW_W-1:0]  cnt_hi;
    logic [NCH-1:0]   wr_sel;

    assign boundary = (cnt == '0);
    assign cnt_hi   = cnt[CNT_W-1:PRESC];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            FRAME <= 1'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            FRAME <= boundary;
        end
    end

    // Channel numbers at or above NCH select nothing.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = WR && (int'(WR_CH) == i);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        servo_channel #(
            .CMD_W           (CMD_W),
            .PW_W            (PW_W),
            .PW_MIN          (PW_MIN),
            .PW_MAX          (PW_MAX),
            .FAILSAFE_FRAMES (FAILSAFE_FRAMES),
            .FAILSAFE_VAL    (FAILSAFE_VAL)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .boundary (boundary),
            .cnt_hi   (cnt_hi),
            .wr       (wr_sel[i]),
            .wr_cmd   (WR_CMD),
            .offset   (OFFSET[i*CMD_W +: CMD_W]),
            .en       (EN[i]),
            .servo    (SERVO[i]),
            .stale    (STALE[i])
        );
    end

endmodule

// File: tb/tb_servo_multi.sv
// Bench for servo_multi: small frame (512 clocks), 3 channels, failsafe after 2 frames.
module tb_servo_multi;

    localparam int NCH       = 3;
    localparam int CNT_W     = 9;
    localparam int PRESC     = 2;
    localparam int CMD_W     = 6;
    localparam int PW_MIN    = 0;
    localparam int PW_MAX    = 100;
    localparam int FS_FRAMES = 2;
    localparam int FS_VAL    = 5;
    localparam int FRAME_LEN = 1 << CNT_W;

    logic                 CLK;
    logic                 RST;
    logic                 WR;
    logic [1:0]           WR_CH;
    logic [CMD_W-1:0]     WR_CMD;
    logic [NCH*CMD_W-1:0] OFFSET;
    logic [NCH-1:0]       EN;
    logic [NCH-1:0]       SERVO;
    logic                 FRAME;
    logic [NCH-1:0]       STALE;

    servo_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .PRESC(PRESC), .CMD_W(CMD_W),
        .PW_MIN(PW_MIN), .PW_MAX(PW_MAX),
        .FAILSAFE_FRAMES(FS_FRAMES), .FAILSAFE_VAL(FS_VAL)
    ) dut (
        .CLK(CLK), .RST(RST), .WR(WR), .WR_CH(WR_CH), .WR_CMD(WR_CMD),
        .OFFSET(OFFSET), .EN(EN), .SERVO(SERVO), .FRAME(FRAME), .STALE(STALE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: counter position, latched widths and freshness per channel.
    int             m_cnt;
    int             m_sh  [NCH];
    int             m_act [NCH];
    int             m_fs  [NCH];
    logic [NCH-1:0] m_en;
    logic [NCH-1:0] m_stale;
    logic [NCH-1:0] m_servo;
    logic           m_frame;

    task automatic m_reset();
        m_cnt = 0;
        for (int i = 0; i < NCH; i++) begin
            m_sh[i] = 0; m_act[i] = 0; m_fs[i] = 0;
        end
        m_en = '0; m_stale = '0; m_servo = '0; m_frame = 1'b0;
    endtask

    task automatic m_step();
        int c;
        c = m_cnt;
        for (int i = 0; i < NCH; i++) begin
            bit wr_i;
            int sum;
            int w;
            wr_i = WR && (int'(WR_CH) == i);
            if (c == 0) begin
                sum = m_sh[i] + int'(OFFSET[i*CMD_W +: CMD_W]);
                w = (sum < PW_MIN) ? PW_MIN : ((sum > PW_MAX) ? PW_MAX : sum);
                if (m_stale[i] || (!wr_i && m_fs[i] + 1 >= FS_FRAMES)) w = FS_VAL;
                m_act[i] = w;
                m_en[i]  = EN[i];
            end
            // Output is high for the first width*2^PRESC clocks of the frame.
            m_servo[i] = m_en[i] && (c < m_act[i] * (1 << PRESC));
            if (wr_i) begin
                m_sh[i] = int'(WR_CMD); m_fs[i] = 0; m_stale[i] = 1'b0;
            end else if (c == 0) begin
                m_fs[i] = (m_fs[i] < FS_FRAMES) ? m_fs[i] + 1 : FS_FRAMES;
                if (m_fs[i] >= FS_FRAMES) m_stale[i] = 1'b1;
            end
        end
        m_frame = (c == 0);
        m_cnt   = (c + 1) % FRAME_LEN;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) m_reset();
            else     m_step();
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    initial begin
        logic [2*NCH:0] got;
        logic [2*NCH:0] exp;
        forever begin
            @(negedge CLK);
            got = {SERVO, STALE, FRAME};
            exp = {m_servo, m_stale, m_frame};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL cycle t=%0t {SERVO,STALE,FRAME}: got %b expected %b", $time, got, exp);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic wait_cnt(input int tgt);
        int n = 0;
        while (m_cnt != tgt && n < 1100) begin
            @(negedge CLK);
            n++;
        end
        if (m_cnt != tgt) timeout("wait_cnt");
    endtask

    // Called at a negedge; WR is seen by the next posedge.
    task automatic write(input int ch, input int cmd);
        WR     = 1'b1;
        WR_CH  = 2'(ch);
        WR_CMD = CMD_W'(cmd);
        @(negedge CLK);
        WR = 1'b0;
    endtask

    // Waits for a FRAME pulse, then counts high clocks per channel over one whole frame.
    task automatic measure(output int wt, output int per, output int h0, output int h1, output int h2);
        wt = 0; per = 0; h0 = 0; h1 = 0; h2 = 0;
        while (FRAME !== 1'b1 && wt < 1100) begin
            @(negedge CLK);
            wt++;
        end
        if (FRAME !== 1'b1) begin
            timeout("measure_frame");
        end else begin
            do begin
                h0 += int'(SERVO[0]);
                h1 += int'(SERVO[1]);
                h2 += int'(SERVO[2]);
                per++;
                @(negedge CLK);
            end while (FRAME !== 1'b1 && per < 1100);
        end
    endtask

    initial begin
        int wt, per, h0, h1, h2;
        RST = 1'b1; WR = 1'b0; WR_CH = '0; WR_CMD = '0; OFFSET = '0; EN = 3'b001;

        repeat (3) @(negedge CLK);
        check("reset_servo", int'(SERVO), 0);
        check("reset_stale", int'(STALE), 0);
        check("reset_frame", int'(FRAME), 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // ch0 cmd 25 -> 100-clock pulse, others disabled
        write(0, 25);
        measure(wt, per, h0, h1, h2);
        check("f1_h0", h0, 100);
        check("f1_h1", h1, 0);
        check("f1_h2", h2, 0);
        check("f1_period", per, FRAME_LEN);

        // two boundaries without a write -> failsafe width 5 = 20 clocks
        check("f2_stale", int'(STALE), 3'b111);
        measure(wt, per, h0, h1, h2);
        check("f2_h0_failsafe", h0, 20);

        // write during the failsafe pulse: pulse untouched, STALE drops next edge
        fork
            measure(wt, per, h0, h1, h2);
            begin
                wait_cnt(10);
                write(0, 50);
                check("f3_stale_clear", int'(STALE[0]), 0);
            end
        join
        check("f3_h0", h0, 20);

        // write mid-pulse: current frame keeps 200, next frame 48
        fork
            measure(wt, per, h0, h1, h2);
            begin
                wait_cnt(100);
                write(0, 12);
            end
        join
        check("f4_h0", h0, 200);

        // EN/OFFSET changes mid-frame wait for the next boundary; channel 3 does not exist
        fork
            measure(wt, per, h0, h1, h2);
            begin
                wait_cnt(20);
                write(1, 63);
                wait_cnt(30);
                write(2, 0);
                wait_cnt(40);
                write(3, 1);
                wait_cnt(50);
                OFFSET = {6'd0, 6'd63, 6'd0};
                EN     = 3'b111;
            end
        join
        check("f5_h0", h0, 48);
        check("f5_h1", h1, 0);
        check("f5_h2", h2, 0);

        // ch1 63+63 clamps to 100 -> 400 clocks; ch2 width 0 -> no pulse; ch0 stale
        measure(wt, per, h0, h1, h2);
        check("f6_h0_failsafe", h0, 20);
        check("f6_h1_clamp", h1, 400);
        check("f6_h2_zero", h2, 0);
        check("f6_period", per, FRAME_LEN);

        fork
            measure(wt, per, h0, h1, h2);
            begin
                wait_cnt(5);
                write(0, 25);
            end
        join
        check("f7_h0", h0, 20);
        check("f7_h1_failsafe", h1, 20);
        check("f7_h2_failsafe", h2, 20);

        // write exactly on the boundary edge: old width this frame, no stale transition
        wait_cnt(0);
        write(0, 40);
        check("f9_stale0", int'(STALE[0]), 0);
        check("f9_stale1", int'(STALE[1]), 1);
        measure(wt, per, h0, h1, h2);
        check("f9_h0_old", h0, 100);
        check("f9_h1", h1, 20);

        fork
            measure(wt, per, h0, h1, h2);
            begin
                wait_cnt(300);
                write(0, 40);
            end
        join
        check("f10_h0_new", h0, 160);

        // asynchronous reset mid-pulse
        wait_cnt(60);
        check("pre_reset_servo0", int'(SERVO[0]), 1);
        #2 RST = 1'b1;
        #1;
        check("async_servo", int'(SERVO), 0);
        check("async_stale", int'(STALE), 0);
        check("async_frame", int'(FRAME), 0);
        OFFSET = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        measure(wt, per, h0, h1, h2);
        check("post_reset_frame_wait", wt, 1);
        check("post_reset_h0", h0, 0);
        check("post_reset_h1", h1, 0);
        check("post_reset_h2", h2, 0);
        check("post_reset_period", per, FRAME_LEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
